// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver, the transmitter and the receive FIFO.
//   UART_WIDTH          - serial byte width
//   RX_FIFO_DEPTH_LOG2  - default log2 depth of the receive buffer
package uart_pkg;

    localparam int unsigned UART_WIDTH         = 8;
    localparam int unsigned RX_FIFO_DEPTH_LOG2 = 4;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO.
// Writes are registered. Reads are asynchronous, so the head byte is available
// in the same cycle that the read pointer changes.
//   clock  in   master clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2,
    parameter int unsigned WIDTH      = UART_WIDTH
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    // The contents are deliberately not reset; reset empties the FIFO through
    // its pointers and count instead.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer that sits directly after the UART receiver.
// Each rising edge of rx_done stores rx_data in a circular FIFO. Bytes are
// presented to the host over a show-ahead valid/ready interface, together with
// occupancy and a sticky overflow flag.
//   reset          in   asynchronous, active-low reset
//   clock          in   master clock
//   rx_data        in   byte from the receiver (held stable while rx_done is high)
//   rx_done        in   byte-complete level from the receiver; only its rising edge counts
//   out_data       out  head-of-FIFO byte, valid while out_valid is high
//   out_valid      out  FIFO not empty
//   out_ready      in   consumer takes the head byte when out_valid & out_ready
//   count          out  occupancy, 0..DEPTH
//   full           out  count == DEPTH
//   overflow       out  sticky flag: a byte was dropped because the FIFO was full
//   clear_overflow in   synchronous clear for overflow
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2,
    parameter int unsigned WIDTH      = UART_WIDTH
) (
    input  logic                  reset,
    input  logic                  clock,
    input  logic [WIDTH-1:0]      rx_data,
    input  logic                  rx_done,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam int unsigned           DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);

    // rx_done synchroniser (s1, s2) and edge-detect flop (s3)
    logic s1_q, s2_q, s3_q;

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;
    logic                  overflow_q, overflow_d;

    logic push, pop, accept, drop;

    // rx_data is not synchronised: the receiver holds it for a full bit period,
    // far longer than the three-flop delay before it is written.
    assign push = s2_q & ~s3_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= rx_done;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign out_valid = (count_q != '0);
    assign full      = (count_q == FULL_COUNT);
    assign count     = count_q;
    assign overflow  = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        pop = out_valid & out_ready;
        // When full, a push is still accepted if a pop frees the head slot in
        // the same cycle: the write lands on the slot being read out.
        accept = push & (~full | pop);
        drop   = push & full & ~pop;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (accept && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !accept) begin
            count_d = count_q - CNT_ONE;
        end

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_mem (
        .clock (clock),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata (rx_data),
        .raddr (rd_ptr_q),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH_LOG2=4, WIDTH=8).
module tb_uart_rx_fifo;

    logic       reset;
    logic       clock;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic       clear_overflow;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0] exp_q[$];

    uart_rx_fifo #(
        .DEPTH_LOG2 (4),
        .WIDTH      (8)
    ) dut (
        .reset          (reset),
        .clock          (clock),
        .rx_data        (rx_data),
        .rx_done        (rx_done),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .count          (count),
        .full           (full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rx_done;
        logic [7:0] rx_data;
        logic       out_ready;
        logic       clr;
        logic       exp_valid;
        logic [4:0] exp_count;
        logic       exp_full;
        logic       exp_ovf;
        logic       chk_data;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Rising edge of rx_done: 3 cycles high, 3 cycles low. Byte lands on the
    // third edge after the first high edge, before this task returns.
    task automatic send_byte(input logic [7:0] d);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            rx_done = 1'b1;
            rx_data = d;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            rx_done = 1'b0;
        end
    endtask

    // One cycle of the streaming test: toggle ready, check any pop against the queue.
    task automatic t5_cycle(input logic rd, input logic [7:0] d, input bit new_byte);
        @(negedge clock);
        rx_done   = rd;
        rx_data   = d;
        out_ready = ~out_ready;
        if (new_byte) exp_q.push_back(d);
        #1;
        check("t5_cnt_le16", 32'(count <= 5'd16), 1);
        check("t5_no_ovf", 32'(overflow), 0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("t5_unexpected_pop", 1, 0);
            end else begin
                check("t5_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    endtask

    initial begin
        reset = 1'b0; rx_done = 1'b0; rx_data = '0;
        out_ready = 1'b0; clear_overflow = 1'b0;

        // ---------------- reset state
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(overflow), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // ---------------- test 1: single byte, table-driven, per-edge checks
        //            rx_done data   rdy clr  valid cnt  full ovf  chkd data
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};
        for (int v = 0; v < 5; v++) begin
            @(negedge clock);
            rx_done        = tbl[v].rx_done;
            rx_data        = tbl[v].rx_data;
            out_ready      = tbl[v].out_ready;
            clear_overflow = tbl[v].clr;
            @(posedge clock);
            #1;
            check($sformatf("t1_valid[%0d]", v), 32'(out_valid), 32'(tbl[v].exp_valid));
            check($sformatf("t1_count[%0d]", v), 32'(count), 32'(tbl[v].exp_count));
            check($sformatf("t1_full[%0d]", v), 32'(full), 32'(tbl[v].exp_full));
            check($sformatf("t1_ovf[%0d]", v), 32'(overflow), 32'(tbl[v].exp_ovf));
            if (tbl[v].chk_data) begin
                check($sformatf("t1_data[%0d]", v), 32'(out_data), 32'(tbl[v].exp_data));
            end
        end

        // ---------------- test 2: held level pushes exactly one byte
        @(negedge clock);
        rx_done = 1'b1; rx_data = 8'h3C; out_ready = 1'b0;
        repeat (50) @(negedge clock);
        rx_done = 1'b0;
        repeat (4) @(negedge clock);
        check("t2_count", 32'(count), 1);
        check("t2_data", 32'(out_data), 32'h3C);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("t2_count_after_pop", 32'(count), 0);

        // ---------------- test 3: fill + overflow, drain in order, clear
        for (int i = 0; i <= 16; i++) send_byte(8'(i));
        check("t3_full", 32'(full), 1);
        check("t3_count", 32'(count), 16);
        check("t3_ovf", 32'(overflow), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t3_drain[%0d]", i), 32'(out_data), 32'(i));
            @(negedge clock);
        end
        out_ready = 1'b0;
        check("t3_empty", 32'(count), 0);
        check("t3_ovf_sticky", 32'(overflow), 1);
        clear_overflow = 1'b1;
        @(negedge clock);
        clear_overflow = 1'b0;
        check("t3_ovf_cleared", 32'(overflow), 0);

        // ---------------- test 4: full FIFO, push coincident with pop
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
        check("t4_full", 32'(full), 1);
        check("t4_ovf0", 32'(overflow), 0);
        @(negedge clock);
        rx_done = 1'b1; rx_data = 8'h77;        // first high edge N follows
        @(negedge clock);                       // after N
        @(negedge clock);                       // after N+1, push active at N+2
        check("t4_head", 32'(out_data), 32'h20);
        out_ready = 1'b1;
        @(negedge clock);                       // after N+2
        out_ready = 1'b0;
        rx_done   = 1'b0;
        check("t4_count", 32'(count), 16);
        check("t4_ovf", 32'(overflow), 0);
        repeat (3) @(negedge clock);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t4_drain[%0d]", i), 32'(out_data),
                  (i == 15) ? 32'h77 : 32'(8'h21 + 8'(i)));
            @(negedge clock);
        end
        out_ready = 1'b0;
        check("t4_empty", 32'(count), 0);

        // ---------------- test 5: 40-byte stream with toggling ready (wraps pointers)
        exp_q.delete();
        for (int b = 0; b < 40; b++) begin
            for (int p = 0; p < 6; p++) begin
                t5_cycle(p < 3, 8'(b * 37 + 11), p == 0);
            end
        end
        for (int c = 0; c < 200 && (exp_q.size() != 0 || count != 0); c++) begin
            t5_cycle(1'b0, 8'h00, 1'b0);
        end
        check("t5_all_out", 32'(exp_q.size()), 0);
        check("t5_empty", 32'(count), 0);
        @(negedge clock);
        out_ready = 1'b0;

        // ---------------- test 6: reset during an rx_done rise
        for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i));
        check("t6_count5", 32'(count), 5);
        @(negedge clock);
        rx_done = 1'b1; rx_data = 8'h99;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_valid", 32'(out_valid), 0);
        check("t6_rst_ovf", 32'(overflow), 0);
        @(negedge clock);
        rx_done = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check("t6_inflight_dropped", 32'(count), 0);
        send_byte(8'h5A);
        check("t6_valid", 32'(out_valid), 1);
        check("t6_count1", 32'(count), 1);
        check("t6_data", 32'(out_data), 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
